// File: rtl/cmd_encod_linear_rw_if.sv
// Request/command bundle between the channel arbiter, the linear
// read/write command encoder and the memory-controller sequencer.
interface cmd_encod_linear_rw_if #(
  parameter int ADDRESS_NUMBER = 15,
  parameter int COLADDR_NUMBER = 10,
  parameter int NUM_XFER_BITS  = 6
);
  logic [2:0]                bank_in;
  logic [ADDRESS_NUMBER-1:0] row_in;
  logic [COLADDR_NUMBER-4:0] start_col;
  logic [NUM_XFER_BITS-1:0]  num128_in;
  logic                      skip_next_page_in;
  logic                      wr_mode_in;
  logic                      start;
  logic                      enc_rdy;
  logic [31:0]               enc_cmd;
  logic                      enc_wr;
  logic                      enc_done;
  logic                      busy;

  // Requester/sequencer side: drives the request and accepts words.
  modport master (
    output bank_in, row_in, start_col, num128_in, skip_next_page_in,
           wr_mode_in, start, enc_rdy,
    input  enc_cmd, enc_wr, enc_done, busy
  );

  // Encoder side.
  modport slave (
    input  bank_in, row_in, start_col, num128_in, skip_next_page_in,
           wr_mode_in, start, enc_rdy,
    output enc_cmd, enc_wr, enc_done, busy
  );
endinterface

// File: rtl/cmd_encod_linear_rw.sv
// Command-sequence encoder for single-page linear DDR3 read or write
// transfers. One 32-bit command word is produced per cycle in which the
// sequencer asserts enc_rdy: ACTIVATE, RCD pause, N column bursts, tail
// pause, page-end marker, PRECHARGE, precharge pause and a done marker.
module cmd_encod_linear_rw #(
  parameter int ADDRESS_NUMBER = 15,
  parameter int COLADDR_NUMBER = 10,
  parameter int NUM_XFER_BITS  = 6,
  parameter int CMD_PAUSE_BITS = 10,
  parameter int CMD_DONE_BIT   = 10,
  parameter int RCD_PAUSE      = 1,
  parameter int RD_TAIL_PAUSE  = 1,
  parameter int WR_TAIL_PAUSE  = 2,
  parameter int PRE_PAUSE      = 2
) (
  input logic                  clk,
  input logic                  rst,
  cmd_encod_linear_rw_if.slave bus
);
  localparam int COL_W = COLADDR_NUMBER - 3;
  localparam int CNT_W = NUM_XFER_BITS + 1;

  localparam logic [2:0] RCW_SKIP = 3'd0;
  localparam logic [2:0] RCW_ACT  = 3'd4;
  localparam logic [2:0] RCW_RD   = 3'd2;
  localparam logic [2:0] RCW_WR   = 3'd3;
  localparam logic [2:0] RCW_PRE  = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_RCD, S_XFER, S_TAIL, S_PGEND, S_PRE, S_PREW, S_FIN
  } state_t;

  state_t                    state_q, state_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bank_q;
  logic [ADDRESS_NUMBER-1:0] row_q;
  logic                      skip_q;
  logic                      wr_q;
  logic [31:0]               cmd_q, cmd_d;
  logic                      enc_wr_q, emit_d;
  logic                      fin_q, fin_d;
  logic                      done_q;
  logic                      load_d;

  // Flag field order: odt_en, cke, sel, dq_en, dqs_en, dqs_toggle, dci,
  // buf_wr, buf_rd, nop, buf_rst. cke is always driven low.
  function automatic logic [10:0] flags(input logic odt, input logic sel,
                                        input logic dq, input logic dqs,
                                        input logic tog, input logic dci,
                                        input logic bwr, input logic brd,
                                        input logic nop, input logic brst);
    return {odt, 1'b0, sel, dq, dqs, tog, dci, bwr, brd, nop, brst};
  endfunction

  function automatic logic [31:0] pack(input logic [14:0] addr,
                                       input logic [2:0] rcw,
                                       input logic [10:0] f);
    return {addr, bank_q, rcw, f};
  endfunction

  function automatic logic [14:0] skip_addr(input logic [CMD_PAUSE_BITS-1:0] n,
                                            input logic done);
    logic [14:0] a;
    a = '0;
    a[CMD_PAUSE_BITS-1:0] = n;
    a[CMD_DONE_BIT] = done;
    return a;
  endfunction

  function automatic logic [14:0] col_addr(input logic [COL_W-1:0] c);
    logic [14:0] a;
    a = '0;
    a[COLADDR_NUMBER-1:3] = c;
    return a;
  endfunction

  function automatic logic [14:0] row_addr(input logic [ADDRESS_NUMBER-1:0] r);
    logic [14:0] a;
    a = '0;
    a[ADDRESS_NUMBER-1:0] = r;
    return a;
  endfunction

  // Next state and the word to emit; every non-idle state emits one word
  // and advances only when the sequencer accepts it.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    cmd_d   = '0;
    emit_d  = 1'b0;
    fin_d   = 1'b0;
    load_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // fin_q still high means the done pulse is pending: stay idle.
        if (bus.start && !fin_q) begin
          load_d  = 1'b1;
          col_d   = bus.start_col;
          cnt_d   = (bus.num128_in == '0) ? CNT_W'(1 << NUM_XFER_BITS)
                                          : {1'b0, bus.num128_in};
          state_d = S_ACT;
        end
      end
      S_ACT: if (bus.enc_rdy) begin
        emit_d  = 1'b1;
        cmd_d   = pack(row_addr(row_q), RCW_ACT, '0);
        state_d = S_RCD;
      end
      S_RCD: if (bus.enc_rdy) begin
        emit_d  = 1'b1;
        cmd_d   = pack(skip_addr(CMD_PAUSE_BITS'(RCD_PAUSE), 1'b0), RCW_SKIP, '0);
        state_d = S_XFER;
      end
      S_XFER: if (bus.enc_rdy) begin
        emit_d = 1'b1;
        cmd_d  = wr_q ? pack(col_addr(col_q), RCW_WR,
                             flags(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0))
                      : pack(col_addr(col_q), RCW_RD,
                             flags(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        col_d  = col_q + COL_W'(1);
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_TAIL;
      end
      S_TAIL: if (bus.enc_rdy) begin
        emit_d  = 1'b1;
        cmd_d   = wr_q ? pack(skip_addr(CMD_PAUSE_BITS'(WR_TAIL_PAUSE), 1'b0), RCW_SKIP,
                              flags(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0))
                       : pack(skip_addr(CMD_PAUSE_BITS'(RD_TAIL_PAUSE), 1'b0), RCW_SKIP,
                              flags(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        state_d = S_PGEND;
      end
      S_PGEND: if (bus.enc_rdy) begin
        emit_d  = 1'b1;
        cmd_d   = pack(skip_addr('0, 1'b0), RCW_SKIP,
                       flags(wr_q, !wr_q, 1'b0, 1'b0, 1'b0, !wr_q, 1'b0, 1'b0, 1'b0, !skip_q));
        state_d = S_PRE;
      end
      S_PRE: if (bus.enc_rdy) begin
        emit_d  = 1'b1;
        cmd_d   = pack(row_addr(row_q), RCW_PRE,
                       flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !wr_q, 1'b0, 1'b0, 1'b0, 1'b0));
        state_d = S_PREW;
      end
      S_PREW: if (bus.enc_rdy) begin
        emit_d  = 1'b1;
        cmd_d   = pack(skip_addr(CMD_PAUSE_BITS'(PRE_PAUSE), 1'b0), RCW_SKIP,
                       flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !wr_q, 1'b0, 1'b0, 1'b0, 1'b0));
        state_d = S_FIN;
      end
      S_FIN: if (bus.enc_rdy) begin
        emit_d  = 1'b1;
        fin_d   = 1'b1;
        cmd_d   = pack(skip_addr('0, 1'b1), RCW_SKIP, '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, counters and registered outputs; enc_cmd holds on stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      cnt_q    <= '0;
      cmd_q    <= '0;
      enc_wr_q <= 1'b0;
      fin_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      enc_wr_q <= emit_d;
      fin_q    <= fin_d;
      done_q   <= fin_q;
      if (emit_d) cmd_q <= cmd_d;
    end
  end

  // Request parameters, captured once per accepted start.
  always_ff @(posedge clk) begin
    if (load_d) begin
      bank_q <= bus.bank_in;
      row_q  <= bus.row_in;
      skip_q <= bus.skip_next_page_in;
      wr_q   <= bus.wr_mode_in;
    end
  end

  assign bus.enc_cmd  = cmd_q;
  assign bus.enc_wr   = enc_wr_q;
  assign bus.enc_done = done_q;
  assign bus.busy     = (state_q != S_IDLE) || fin_q;
endmodule

// File: tb/tb_cmd_encod_linear_rw.sv
// Scoreboard bench for cmd_encod_linear_rw: requests push expected words,
// a negedge monitor pops and compares every word presented with enc_wr.
module tb_cmd_encod_linear_rw;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;
  logic bp_chk = 1'b0;
  logic rdy_prev = 1'b1;
  logic [31:0] sb[$];

  localparam logic [10:0] F_ODT = 11'h400, F_SEL = 11'h100, F_DQ = 11'h080,
                          F_DQS = 11'h040, F_TOG = 11'h020, F_DCI = 11'h010,
                          F_BWR = 11'h008, F_BRD = 11'h004, F_NOP = 11'h002,
                          F_RST = 11'h001;

  cmd_encod_linear_rw_if bus ();

  cmd_encod_linear_rw dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every presented word; check stall slots carry no word.
  always @(negedge clk) begin
    if (bp_chk && !rdy_prev) begin
      checks++;
      if (bus.enc_wr !== 1'b0) begin
        errors++;
        $display("FAIL stall_slot cyc=%0d enc_wr=%b required 0", cyc, bus.enc_wr);
      end
    end
    rdy_prev = bus.enc_rdy;
    if (bus.enc_wr === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word cyc=%0d got %h with empty scoreboard", cyc, bus.enc_cmd);
      end else begin
        logic [31:0] exp;
        exp = sb.pop_front();
        popped++;
        if (bus.enc_cmd !== exp) begin
          errors++;
          $display("FAIL word cyc=%0d got %h required %h", cyc, bus.enc_cmd, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [14:0] a, input logic [2:0] b,
                                     input logic [2:0] r, input logic [10:0] f);
    return {a, b, r, f};
  endfunction

  // Reference sequence from the command format description.
  task automatic push_req(input logic [2:0] b, input logic [14:0] row, input int col,
                          input int n, input logic skip, input logic wr);
    int nb;
    nb = (n == 0) ? 64 : n;
    sb.push_back(mk(row, b, 3'd4, 11'h0));
    sb.push_back(mk(15'd1, b, 3'd0, 11'h0));
    for (int i = 0; i < nb; i++) begin
      logic [14:0] ca;
      ca = 15'(((col + i) % 128) * 8);
      sb.push_back(wr ? mk(ca, b, 3'd3, F_ODT | F_SEL | F_DQ | F_DQS | F_TOG | F_BRD | F_NOP)
                      : mk(ca, b, 3'd2, F_SEL | F_DCI | F_BWR | F_NOP));
    end
    sb.push_back(wr ? mk(15'd2, b, 3'd0, F_ODT | F_SEL | F_DQ | F_DQS)
                    : mk(15'd1, b, 3'd0, F_SEL | F_DCI));
    sb.push_back(mk(15'd0, b, 3'd0, (wr ? F_ODT : (F_SEL | F_DCI)) | (skip ? 11'h0 : F_RST)));
    sb.push_back(mk(row, b, 3'd5, wr ? 11'h0 : F_DCI));
    sb.push_back(mk(15'd2, b, 3'd0, wr ? 11'h0 : F_DCI));
    sb.push_back(mk(15'h400, b, 3'd0, 11'h0));
  endtask

  // Issue a start for one cycle; returns T (cycle in which start is high).
  task automatic start_req(input logic [2:0] b, input logic [14:0] row, input logic [6:0] col,
                           input logic [5:0] n, input logic skip, input logic wr,
                           output int t);
    @(posedge clk); #1;
    bus.bank_in = b; bus.row_in = row; bus.start_col = col; bus.num128_in = n;
    bus.skip_next_page_in = skip; bus.wr_mode_in = wr; bus.start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", {31'b0, bus.busy}, 32'd1);
  endtask

  task automatic wait_done(input logic bp, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      bus.enc_rdy = bp ? ~bus.enc_rdy : 1'b1;
      @(negedge clk);
      if (bus.enc_done === 1'b1) begin
        dcyc = cyc;
        break;
      end
    end
    if (dcyc < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout no enc_done within 400 cycles");
    end else begin
      chk("busy_in_done_cycle", {31'b0, bus.busy}, 32'd0);
    end
    @(posedge clk); #1;
    bus.enc_rdy = 1'b1;
  endtask

  initial begin
    int t, d, p0;
    bus.bank_in = '0; bus.row_in = '0; bus.start_col = '0; bus.num128_in = '0;
    bus.skip_next_page_in = 1'b0; bus.wr_mode_in = 1'b0; bus.start = 1'b0;
    bus.enc_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_enc_cmd", bus.enc_cmd, 32'h0);
    chk("rst_enc_wr", {31'b0, bus.enc_wr}, 32'd0);
    chk("rst_enc_done", {31'b0, bus.enc_done}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Read, bank 3, row 0x1234, col 5, 4 bursts: hand-computed words.
    sb.push_back(32'h2468E000); sb.push_back(32'h0002C000);
    sb.push_back(32'h0050D11A); sb.push_back(32'h0060D11A);
    sb.push_back(32'h0070D11A); sb.push_back(32'h0080D11A);
    sb.push_back(32'h0002C110); sb.push_back(32'h0000C111);
    sb.push_back(32'h2468E810); sb.push_back(32'h0004C010);
    sb.push_back(32'h0800C000);
    p0 = popped;
    start_req(3'd3, 15'h1234, 7'd5, 6'd4, 1'b0, 1'b0, t);
    // A start while busy with different fields must be ignored.
    @(posedge clk); #1;
    bus.bank_in = 3'd7; bus.row_in = 15'h7FFF; bus.wr_mode_in = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(1'b0, d);
    chk("read_done_cycle", d - t, 32'd13);
    chk("read_word_count", popped - p0, 32'd11);

    // Write, one burst, skip_next_page set.
    p0 = popped;
    push_req(3'd1, 15'h0ABC, 16, 1, 1'b1, 1'b1);
    start_req(3'd1, 15'h0ABC, 7'h10, 6'd1, 1'b1, 1'b1, t);
    wait_done(1'b0, d);
    chk("write_done_cycle", d - t, 32'd10);
    chk("write_word_count", popped - p0, 32'd8);

    // Full depth with column wrap inside the page.
    p0 = popped;
    push_req(3'd2, 15'h7FFF, 'h70, 0, 1'b0, 1'b0);
    start_req(3'd2, 15'h7FFF, 7'h70, 6'd0, 1'b0, 1'b0, t);
    wait_done(1'b0, d);
    chk("full_done_cycle", d - t, 32'd73);
    chk("full_word_count", popped - p0, 32'd71);

    // Backpressure: enc_rdy toggles every cycle, same words expected.
    p0 = popped;
    push_req(3'd3, 15'h1234, 5, 4, 1'b0, 1'b0);
    bp_chk = 1'b1;
    start_req(3'd3, 15'h1234, 7'd5, 6'd4, 1'b0, 1'b0, t);
    wait_done(1'b1, d);
    bp_chk = 1'b0;
    chk("bp_word_count", popped - p0, 32'd11);

    // Reset during XFER: ACT, RCD and first READ appear, then abort.
    sb.push_back(mk(15'h0155, 3'd5, 3'd4, 11'h0));
    sb.push_back(mk(15'd1, 3'd5, 3'd0, 11'h0));
    sb.push_back(mk(15'h0010, 3'd5, 3'd2, F_SEL | F_DCI | F_BWR | F_NOP));
    start_req(3'd5, 15'h0155, 7'd2, 6'd8, 1'b0, 1'b0, t);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_enc_cmd", bus.enc_cmd, 32'h0);
    chk("abort_enc_wr", {31'b0, bus.enc_wr}, 32'd0);
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (bus.enc_done === 1'b1) seen = 1'b1;
      end
      chk("abort_no_done", {31'b0, seen}, 32'd0);
    end
    chk("abort_sb_empty", sb.size(), 32'd0);

    // A fresh write request after the abort completes normally.
    p0 = popped;
    push_req(3'd6, 15'h2A2A, 'h7E, 3, 1'b0, 1'b1);
    start_req(3'd6, 15'h2A2A, 7'h7E, 6'd3, 1'b0, 1'b1, t);
    wait_done(1'b0, d);
    chk("after_abort_done_cycle", d - t, 32'd12);
    chk("after_abort_word_count", popped - p0, 32'd10);

    repeat (3) @(posedge clk);
    chk("final_sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmd_encod_linear_rw.md
# cmd_encod_linear_rw

Parametrised command-sequence encoder for single-page linear DDR3 transfers, read or write selected per request. It sits between the channel arbiter and the memory-controller sequencer. For each request it emits one encoded 32-bit command word per accepted cycle: ACTIVATE, column bursts, tail pauses, PRECHARGE, done marker. It adds over the read-only generation: write mode, configurable pauses, full-depth transfers and per-word `enc_rdy` backpressure.

## Interface
- ADDRESS_NUMBER, 15, row address width (≤15)
- COLADDR_NUMBER, 10, column address width; bursts addressed by [COLADDR_NUMBER-1:3]
- NUM_XFER_BITS, 6, transfer-length width; 0 encodes 2^NUM_XFER_BITS bursts
- CMD_PAUSE_BITS, 10, skip-count field width
- CMD_DONE_BIT, 10, address bit carrying "done" in skip words (≥CMD_PAUSE_BITS, ≤14)
- RCD_PAUSE, 1, extra skip cycles after ACTIVATE
- RD_TAIL_PAUSE, 1, skip after last READ
- WR_TAIL_PAUSE, 2, skip after last WRITE (write recovery)
- PRE_PAUSE, 2, skip after PRECHARGE
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- bank_in  in  3  bank
- row_in  in  ADDRESS_NUMBER  row
- start_col  in  COLADDR_NUMBER-3  start column in 8-bursts
- num128_in  in  NUM_XFER_BITS  burst count
- skip_next_page_in  in  1  suppress buf_rst on page end
- wr_mode_in  in  1  0 = read, 1 = write
- start  in  1  request strobe, sampled only when idle
- enc_rdy  in  1  sequencer accepts a word this cycle
- enc_cmd  out  32  encoded word, reg
- enc_wr  out  1  enc_cmd valid, reg
- enc_done  out  1  one-cycle end pulse, reg
- busy  out  1  request in progress

## Operation
- Word format, MSB→LSB: addr[14:0], bank[2:0], rcw[2:0], odt_en, cke, sel, dq_en, dqs_en, dqs_toggle, dci, buf_wr, buf_rd, nop, buf_rst.
- Skip word: rcw=0, nop=0, addr = skip count in [CMD_PAUSE_BITS-1:0], done flag at bit CMD_DONE_BIT, other addr bits 0.
- rcw values: ACTIVATE=4, READ=2, WRITE=3, PRECHARGE=5.
- Column word addr: {0, col, 3'b000}.
- cke is always 0. bank is the latched bank in every word.
- On start while idle, latch bank, row, start_col, num128, skip_next_page and mode. The burst count N is num128_in, or 2^NUM_XFER_BITS if num128_in is 0.
- States: IDLE→ACT→RCD→XFER(×N)→TAIL→PGEND→PRE→PREW→FIN→IDLE.
- Each non-IDLE state emits exactly one word, and only in a cycle with enc_rdy=1.
- ACT: ACTIVATE, addr=row, all flags 0.
- RCD: skip RCD_PAUSE, flags 0.
- XFER, read mode: READ, nop=1, sel=1, dci=1, buf_wr=1.
- XFER, write mode: WRITE, nop=1, sel=1, odt_en=1, dq_en=1, dqs_en=1, dqs_toggle=1, buf_rd=1.
- XFER: col increments after each emitted burst, modulo 2^(COLADDR_NUMBER-3) (wraps inside the page).
- TAIL, read: skip RD_TAIL_PAUSE, sel=1, dci=1.
- TAIL, write: skip WR_TAIL_PAUSE, sel=1, odt_en=1, dq_en=1, dqs_en=1, dqs_toggle=0.
- PGEND: skip 0, read flags as TAIL-read, write flags odt_en=1 only; buf_rst = !skip_next_page.
- PRE: PRECHARGE, addr=row; dci = read mode.
- PREW: skip PRE_PAUSE; dci = read mode.
- FIN: skip 0, done=1, all flags 0.
- Total words per request: N+7.
- start is ignored while busy; latched values are never modified mid-request.

## Timing
- Reset: enc_cmd=0, enc_wr=0, enc_done=0, busy=0, state IDLE, counters 0; this holds from the cycle after rst is high. rst mid-request aborts with no enc_done.
- start at cycle T: busy=1 from T+1.
- Emission: a word emitted in cycle C (state≠IDLE, enc_rdy=1) appears as enc_cmd with enc_wr=1 at C+1.
- Stall: if enc_rdy=0 in C, enc_wr=0 at C+1, the state holds, and enc_cmd keeps its previous value.
- With enc_rdy held high, words appear at T+2 … T+N+8.
- enc_done=1 for the single cycle after the FIN word's enc_wr; busy drops to 0 in that same cycle.
- The earliest next start is accepted in the enc_done cycle.
- Burst counter: down-counter of NUM_XFER_BITS+1 bits, so N=2^NUM_XFER_BITS needs no special case.

## Test plan
- Read: bank=3, row=0x1234, col=5, num128=4, rdy=1.
  - 11 words.
  - READ addrs 0x028, 0x030, 0x038, 0x040.
  - PGEND buf_rst=1; enc_done at T+13.
- Write: num128=1, skip_next_page=1.
  - 8 words.
  - WRITE word has odt/dq/dqs/dqs_toggle/buf_rd/nop=1.
  - TAIL skip=2; PGEND buf_rst=0.
- Full depth with wrap: num128=0, start_col=0x70.
  - 64 bursts; columns wrap 0x7F→0x00.
  - 71 words.
- Backpressure: enc_rdy toggling 1,0,1,0.
  - Same word sequence as with constant rdy.
  - No duplicated or skipped word; enc_wr low in each stall slot.
- start while busy is ignored. rst asserted during XFER: all outputs 0 next cycle, no enc_done; a new request then completes normally.
